// File: rtl/fifo_rd_packer.sv
// Packs RATIO first-word-fall-through FIFO words into one little-endian output beat.
// Latency: m_valid rises one cycle after the pop that completes a beat; flush closes a partial beat and the packet.
// Backpressure: one output register; pops stall only on the last lane while the output register is busy, or while a flush waits.
module fifo_rd_packer #(
    parameter int DWIDTH    = 32,
    parameter int RATIO     = 4,
    parameter int PKT_BEATS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DWIDTH-1:0]       fifo_rd_data,
    input  logic                    fifo_rd_empty,
    output logic                    fifo_rd_en,
    input  logic                    flush,
    output logic [DWIDTH*RATIO-1:0] m_data,
    output logic [RATIO-1:0]        m_keep,
    output logic                    m_last,
    output logic                    m_valid,
    input  logic                    m_ready
);
    localparam int CW = $clog2(RATIO);
    localparam int BW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam logic [CW-1:0] CNT_TOP  = CW'(RATIO - 1);
    localparam logic [BW-1:0] BEAT_TOP = BW'(PKT_BEATS - 1);

    logic [RATIO-1:0][DWIDTH-1:0] r_pack;
    logic [CW-1:0]                r_cnt;
    logic                         r_flush_pend;
    logic [BW-1:0]                r_beat;
    logic [DWIDTH*RATIO-1:0]      r_m_data;
    logic [RATIO-1:0]             r_m_keep;
    logic                         r_m_last;
    logic                         r_m_valid;

    logic                         w_out_free;
    logic                         w_cnt_top;
    logic                         w_pop;
    logic                         w_load_full;
    logic                         w_load_part;
    logic                         w_full_last;
    logic [RATIO-1:0][DWIDTH-1:0] w_full_data;
    logic [RATIO-1:0][DWIDTH-1:0] w_part_data;
    logic [RATIO-1:0]             w_part_keep;

    assign w_out_free  = !r_m_valid || m_ready;
    assign w_cnt_top   = (r_cnt == CNT_TOP);
    assign fifo_rd_en  = rst_n && !r_flush_pend && (!w_cnt_top || w_out_free);
    assign w_pop       = fifo_rd_en && !fifo_rd_empty;
    assign w_load_full = w_pop && w_cnt_top;
    assign w_load_part = r_flush_pend && w_out_free;
    // A flush arriving with the beat-completing pop closes the packet on that full beat.
    assign w_full_last = flush || (r_beat == BEAT_TOP);

    always_comb begin
        w_full_data          = r_pack;
        w_full_data[RATIO-1] = fifo_rd_data;
        w_part_data          = '0;
        w_part_keep          = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (k < int'(r_cnt)) begin
                w_part_data[k] = r_pack[k];
                w_part_keep[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack       <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_beat       <= '0;
            r_m_data     <= '0;
            r_m_keep     <= '0;
            r_m_last     <= 1'b0;
            r_m_valid    <= 1'b0;
        end else begin
            if (w_pop) begin
                if (w_cnt_top) begin
                    r_cnt <= '0;
                end else begin
                    r_pack[r_cnt] <= fifo_rd_data;
                    r_cnt         <= r_cnt + CW'(1);
                end
            end

            if (w_load_full) begin
                r_m_data  <= w_full_data;
                r_m_keep  <= '1;
                r_m_last  <= w_full_last;
                r_m_valid <= 1'b1;
                r_beat    <= w_full_last ? '0 : r_beat + BW'(1);
            end else if (w_load_part) begin
                r_m_data     <= w_part_data;
                r_m_keep     <= w_part_keep;
                r_m_last     <= 1'b1;
                r_m_valid    <= 1'b1;
                r_beat       <= '0;
                r_cnt        <= '0;
                r_flush_pend <= 1'b0;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end

            // Pending flush blocks further pops until the partial beat can load.
            if (flush && !r_flush_pend && !w_load_full && (w_pop || (r_cnt != '0))) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign m_data  = r_m_data;
    assign m_keep  = r_m_keep;
    assign m_last  = r_m_last;
    assign m_valid = r_m_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: per-cycle vector table, hand-written stall/reset sequences,
// and randomized traffic scored against a queue-based packet model.
module tb_fifo_rd_packer;
    localparam int DW = 8;
    localparam int R  = 4;
    localparam int PB = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty = 1'b1;
    logic          fifo_rd_en;
    logic          flush = 1'b0;
    logic [31:0]   m_data;
    logic [3:0]    m_keep;
    logic          m_last;
    logic          m_valid;
    logic          m_ready = 1'b0;

    always #5 clk = ~clk;

    fifo_rd_packer #(.DWIDTH(DW), .RATIO(R), .PKT_BEATS(PB)) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty), .fifo_rd_en(fifo_rd_en),
        .flush(flush),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
    );

    typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
    typedef struct {
        bit push; logic [7:0] pd; bit fl; bit rdy;
        bit ev; logic [31:0] ed; logic [3:0] ek; bit el; bit er;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q[$];
    logic [7:0] acc[$];
    beat_t      exp_q[$];
    int         beatno = 0;
    bit         prev_hold = 0;
    beat_t      prev_beat;
    vec_t       tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t v(input bit push, input logic [7:0] pd, input bit fl, input bit rdy,
                               input bit ev, input logic [31:0] ed, input logic [3:0] ek,
                               input bit el, input bit er);
        vec_t r;
        r.push = push; r.pd = pd; r.fl = fl; r.rdy = rdy;
        r.ev = ev; r.ed = ed; r.ek = ek; r.el = el; r.er = er;
        return r;
    endfunction

    // Packet model: words gather into a beat; a beat closes on RATIO words, or on flush with words held.
    task automatic model_step(input bit pop, input bit fl, input logic [7:0] w);
        beat_t b;
        if (pop) acc.push_back(w);
        if (acc.size() == R || (fl && acc.size() > 0)) begin
            b = '0;
            foreach (acc[i]) begin
                b.d[i*DW +: DW] = acc[i];
                b.k[i]          = 1'b1;
            end
            b.l    = fl || (beatno == PB - 1);
            beatno = b.l ? 0 : beatno + 1;
            exp_q.push_back(b);
            acc.delete();
        end
    endtask

    task automatic drive(input bit push, input logic [7:0] pd, input bit fl, input bit rdy);
        @(negedge clk);
        if (push) q.push_back(pd);
        flush         = fl;
        m_ready       = rdy;
        fifo_rd_empty = (q.size() == 0);
        fifo_rd_data  = (q.size() == 0) ? 8'h00 : q[0];
        #1;
    endtask

    task automatic tick();
        bit    pop;
        bit    xfer;
        beat_t got;
        beat_t e;
        pop   = fifo_rd_en && !fifo_rd_empty;
        xfer  = m_valid && m_ready;
        got.d = m_data; got.k = m_keep; got.l = m_last;
        if (prev_hold) begin
            check("hold_vld", 32'(m_valid), 32'd1);
            check("hold_dat", m_data, prev_beat.d);
            check("hold_keep_last", 32'({m_keep, m_last}), 32'({prev_beat.k, prev_beat.l}));
        end
        if (xfer) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_beat: got %h keep %h last %0d, expected no beat", m_data, m_keep, m_last);
            end else begin
                e = exp_q.pop_front();
                check("beat_dat", m_data, e.d);
                check("beat_keep", 32'(m_keep), 32'(e.k));
                check("beat_last", 32'(m_last), 32'(e.l));
            end
        end
        prev_hold = m_valid && !m_ready;
        prev_beat = got;
        model_step(pop, flush, fifo_rd_data);
        @(posedge clk);
        if (pop) void'(q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        fifo_rd_empty = 1'b0; fifo_rd_data = 8'h5A; m_ready = 1'b1; flush = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_vld", 32'(m_valid), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_dat", m_data, 32'd0);
        check("rst_keep", 32'(m_keep), 32'd0);
        check("rst_rden", 32'(fifo_rd_en), 32'd0);
        q.delete(); acc.delete(); exp_q.delete();
        beatno = 0; prev_hold = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rden_clk", 32'(fifo_rd_en), 32'd0);
        check("rst_vld_clk", 32'(m_valid), 32'd0);
        fifo_rd_empty = 1'b1; fifo_rd_data = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming, partial flush, flush on the completing pop, ignored flush.
        for (int i = 0; i < 4; i++) tbl.push_back(v(1, 8'h01 + 8'(i), 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 8'h05, 0, 1, 1, 32'h04030201, 4'hF, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 8'h06 + 8'(i), 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h08070605, 4'hF, 1, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 8'hA1, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 8'hA2, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h0000A2A1, 4'h3, 1, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 8'hB1 + 8'(i), 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 8'hB4, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'hB4B3B2B1, 4'hF, 1, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(v(1, 8'hD1 + 8'(i), 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'hD4D3D2D1, 4'hF, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(v(1, 8'hE1 + 8'(i), 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'hE4E3E2E1, 4'hF, 1, 1));
        tbl.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 1));
        for (int i = 0; i < 10; i++) tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1));

        do_reset();

        foreach (tbl[i]) begin
            drive(tbl[i].push, tbl[i].pd, tbl[i].fl, tbl[i].rdy);
            check($sformatf("tbl%0d_vld", i), 32'(m_valid), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_rden", i), 32'(fifo_rd_en), 32'(tbl[i].er));
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_dat", i), m_data, tbl[i].ed);
                check($sformatf("tbl%0d_keep", i), 32'(m_keep), 32'(tbl[i].ek));
                check($sformatf("tbl%0d_last", i), 32'(m_last), 32'(tbl[i].el));
            end
            tick();
        end

        // Output stalled: first beat holds, packing stops on the last lane.
        for (int i = 0; i < 8; i++) q.push_back(8'h11 + 8'(i));
        for (int c = 0; c < 7; c++) begin drive(0, 0, 0, 0); tick(); end
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0, 0);
            check("stall_rden", 32'(fifo_rd_en), 32'd0);
            check("stall_head", 32'(fifo_rd_data), 32'h18);
            check("stall_dat", m_data, 32'h14131211);
            tick();
        end
        drive(0, 0, 0, 1);
        check("release_rden", 32'(fifo_rd_en), 32'd1);
        tick();
        drive(0, 0, 0, 1);
        check("release_vld", 32'(m_valid), 32'd1);
        check("release_dat", m_data, 32'h18171615);
        check("release_last", 32'(m_last), 32'd1);
        tick();

        // Reset with a beat held and two words packed.
        for (int i = 0; i < 6; i++) q.push_back(8'h21 + 8'(i));
        for (int c = 0; c < 6; c++) begin drive(0, 0, 0, 0); tick(); end
        check("pre_rst_vld", 32'(m_valid), 32'd1);
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1, 8'hC1 + 8'(i), 0, 1); tick(); end
        drive(0, 0, 0, 1);
        check("post_rst_vld", 32'(m_valid), 32'd1);
        check("post_rst_dat", m_data, 32'hC4C3C2C1);
        check("post_rst_last", 32'(m_last), 32'd0);
        tick();

        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7);
            tick();
        end
        for (int c = 0; c < 600 && q.size() > 0; c++) begin drive(0, 0, 0, 1); tick(); end
        check("drain_fifo", q.size(), 32'd0);
        drive(0, 0, 1, 1); tick();
        for (int c = 0; c < 20 && (exp_q.size() > 0 || m_valid); c++) begin drive(0, 0, 0, 1); tick(); end
        check("drain_beats", exp_q.size(), 32'd0);
        check("drain_vld", 32'(m_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Parameters
REQ-001 DWIDTH, default 32, width of one FIFO word (>=1); SHALL be the width of fifo_rd_data.
REQ-002 RATIO, default 4, FIFO words per output beat (>=2); output data width SHALL be DWIDTH*RATIO.
REQ-003 PKT_BEATS, default 16, full beats per packet (>=1); the last full beat of a packet SHALL carry m_last.

Interface
REQ-004 clk  in  1  single clock; every register SHALL be clocked on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 fifo_rd_data  in  DWIDTH  FIFO head word, valid whenever fifo_rd_empty=0 (first-word-fall-through).
REQ-007 fifo_rd_empty  in  1  FIFO empty flag.
REQ-008 fifo_rd_en  out  1  pop request; a pop SHALL occur when fifo_rd_en=1 and fifo_rd_empty=0 in the same cycle.
REQ-009 flush  in  1  single-cycle request to close the current partial beat and the packet.
REQ-010 m_data  out  DWIDTH*RATIO  packed output beat.
REQ-011 m_keep  out  RATIO  lane-valid mask, one bit per DWIDTH lane.
REQ-012 m_last  out  1  end-of-packet marker.
REQ-013 m_valid  out  1  beat valid; m_ready  in  1  downstream accept. A transfer SHALL occur when m_valid=1 and m_ready=1.

Function
REQ-014 Lane order SHALL be little-endian: the k-th popped word of a beat SHALL occupy m_data[k*DWIDTH +: DWIDTH], with k counting from 0.
REQ-015 The block SHALL hold a pack register with a lane count cnt (0..RATIO-1), a single output register, a pending-flush flag, and a beat counter (0..PKT_BEATS-1).
REQ-016 fifo_rd_en SHALL be 1 when: flush_pending=0, and either cnt<RATIO-1, or the output register is free (m_valid=0 or m_ready=1).
REQ-017 fifo_rd_en SHALL be combinational and SHALL be 0 while rst_n=0.
REQ-018 On a pop with cnt<RATIO-1, the word SHALL be stored in lane cnt and cnt SHALL increment.
REQ-019 On a pop with cnt=RATIO-1:
- the completed beat SHALL load the output register (m_keep all ones) and m_valid=1 SHALL appear the next cycle;
- cnt SHALL wrap to 0.
REQ-020 Latency: from the clock edge of the pop that completes a beat to m_valid=1 SHALL be one cycle. Throughput SHALL be one beat per RATIO cycles with no back-pressure.
REQ-021 m_data, m_keep and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-022 m_valid SHALL clear after a transfer unless a new beat loads in the same cycle.
REQ-023 m_last SHALL be 1 on full beat number PKT_BEATS-1 (beat counter value). The beat counter SHALL advance per full beat loaded and wrap to 0 after m_last.
REQ-024 flush with cnt=0 and no same-cycle pop SHALL be ignored; no empty beat SHALL be emitted.
REQ-025 flush with a same-cycle pop SHALL include the popped word in the beat before flush handling.
REQ-026 If that same-cycle pop completes a beat (cnt was RATIO-1), the full beat SHALL load with m_last=1, the beat counter SHALL reset, and no pending flag SHALL be set.
REQ-027 Otherwise, flush with cnt>0 (after the pop) SHALL set flush_pending.
REQ-028 While flush_pending=1 and the output register is free, the partial beat SHALL load with:
- m_keep = lower cnt bits set;
- unused lanes zero;
- m_last=1.
In the same cycle cnt, flush_pending and the beat counter SHALL clear.
REQ-029 flush asserted while flush_pending=1 SHALL have no additional effect.
REQ-030 m_keep SHALL be all ones on every non-flush beat.

Reset
REQ-031 While rst_n=0, regardless of clk, the following SHALL all be 0:
- m_valid, m_last, m_data, m_keep;
- cnt, flush_pending, the beat counter;
- fifo_rd_en.
REQ-032 Reset mid-beat or mid-packet SHALL discard all packed words and any held output beat. The first pop after release SHALL land in lane 0 of beat 0.

Verification (DWIDTH=8, RATIO=4, PKT_BEATS=2)
REQ-033 FIFO holds 0x01..0x08, m_ready=1 -> beat 0x04030201 keep 0xF last 0, then 0x08070605 keep 0xF last 1; one beat per 4 cycles.
REQ-034 m_ready=0, FIFO holds 0x11..0x18 -> beat 0x14131211 held stable and cnt stops at 3. fifo_rd_en=0 while 0x18 is at the FIFO head. After m_ready=1, beat 0x18171615 follows one cycle after the pop of 0x18.
REQ-035 Pop 0xA1, 0xA2, then flush with FIFO empty -> beat 0x0000A2A1 keep 0x3 last 1. The next beat after 4 pops has last 0 (beat counter reset).
REQ-036 flush in the same cycle as the 4th pop of 0xB1..0xB4 -> single beat 0xB4B3B2B1 keep 0xF last 1; no extra beat.
REQ-037 flush with cnt=0 and FIFO empty -> m_valid stays 0 for 10 cycles.
REQ-038 rst_n pulsed low after 2 pops with m_valid=1 held -> m_valid=0 immediately. Next 4 pops 0xC1..0xC4 -> beat 0xC4C3C2C1 last 0.
